// File: rtl/mult_div_unit_if.sv
// Operand/control bundle between the EX-stage controller and the multiply/divide
// unit, plus the HI/LO/Busy status that flows back to the controller.
interface mult_div_unit_if;
  logic [31:0] RS_IN;
  logic [31:0] RT_IN;
  logic [2:0]  Op;
  logic        Start;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (
    output RS_IN, RT_IN, Op, Start,
    input  Busy, HI, LO
  );

  modport slave (
    input  RS_IN, RT_IN, Op, Start,
    output Busy, HI, LO
  );
endinterface

// File: rtl/mult_div_unit.sv
// Multi-cycle MIPS multiply/divide unit with architectural HI/LO registers.
// The result is computed when the op is issued and committed after a fixed latency.
module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic              clk,
  input  logic              Reset,
  mult_div_unit_if.slave    bus,
  output logic [1:0]        dbg_state
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   hi_q, hi_d;
  logic [31:0]   lo_q, lo_d;
  logic [63:0]   res_q, res_d;
  logic          commit_q, commit_d;

  logic [31:0]        a, b;
  logic signed [63:0] prod_s;
  logic [63:0]        prod_u;
  logic [31:0]        quot_s, rem_s, quot_u, rem_u;
  logic               b_zero;

  // Arithmetic datapath: evaluated from the live operands, captured only at issue.
  always_comb begin
    a      = bus.RS_IN;
    b      = bus.RT_IN;
    b_zero = (b == 32'd0);
    prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    prod_u = {32'd0, a} * {32'd0, b};
    quot_s = 32'd0;
    rem_s  = 32'd0;
    quot_u = 32'd0;
    rem_u  = 32'd0;
    if (!b_zero) begin
      quot_u = a / b;
      rem_u  = a % b;
      // The most-negative / -1 case wraps instead of overflowing.
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        quot_s = 32'h8000_0000;
        rem_s  = 32'd0;
      end else begin
        quot_s = $signed(a) / $signed(b);
        rem_s  = $signed(a) % $signed(b);
      end
    end
  end

  // Handshake: an op is accepted only on an edge where Start=1 and Busy=0 (Busy as
  // seen before that edge); Busy stays high until the commit edge and the unit never
  // queues, so the controller must hold off Start while Busy is high.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    res_d    = res_q;
    commit_d = commit_q;
    case (state_q)
      S_IDLE: begin
        if (bus.Start) begin
          case (bus.Op)
            OP_MULT, OP_MULTU: begin
              res_d    = (bus.Op == OP_MULT) ? prod_s : prod_u;
              commit_d = 1'b1;
              cnt_d    = CW'(MULT_CYCLES);
              state_d  = S_BUSY;
            end
            OP_DIV, OP_DIVU: begin
              res_d    = (bus.Op == OP_DIV) ? {rem_s, quot_s} : {rem_u, quot_u};
              commit_d = !b_zero;
              cnt_d    = CW'(DIV_CYCLES);
              state_d  = S_BUSY;
            end
            OP_MTHI: hi_d = bus.RS_IN;
            OP_MTLO: lo_d = bus.RS_IN;
            default: ;
          endcase
        end
      end
      S_BUSY: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = S_IDLE;
          if (commit_q) begin
            hi_d = res_q[63:32];
            lo_d = res_q[31:0];
          end
          commit_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      res_q    <= 64'd0;
      commit_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      res_q    <= res_d;
      commit_q <= commit_d;
    end
  end

  assign bus.Busy  = (state_q == S_BUSY);
  assign bus.HI    = hi_q;
  assign bus.LO    = lo_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed-vector bench for mult_div_unit: arithmetic, latency, mthi/mtlo,
// ignored Starts, divide-by-zero, reset abort and commit-edge behaviour.
module tb_mult_div_unit;

  logic       clk = 1'b0;
  logic       Reset;
  logic [1:0] dbg_state;
  int         n_vec = 0;
  int         n_err = 0;

  mult_div_unit_if bus ();

  mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk       (clk),
    .Reset     (Reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt);
    bus.Op    = op;
    bus.RS_IN = rs;
    bus.RT_IN = rt;
    bus.Start = 1'b1;
    step();
    bus.Start = 1'b0;
  endtask

  // Steps until Busy drops (bounded); reports edges taken and whether HI/LO held.
  task automatic wait_idle(input int limit, output int edges, output logic held);
    logic [31:0] h0, l0;
    h0    = bus.HI;
    l0    = bus.LO;
    edges = 0;
    held  = 1'b1;
    while (bus.Busy === 1'b1 && edges < limit) begin
      if (bus.HI !== h0 || bus.LO !== l0) held = 1'b0;
      step();
      edges++;
    end
  endtask

  task automatic exec(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                      output int edges, output logic held);
    issue(op, rs, rt);
    wait_idle(40, edges, held);
  endtask

  // ---------------- test tasks ----------------
  task automatic test_reset();
    Reset = 1'b1;
    step();
    step();
    Reset = 1'b0;
    n_vec++; if (bus.HI !== 32'd0) begin n_err++; $display("FAIL reset_hi: got %h want %h", bus.HI, 32'd0); end
    n_vec++; if (bus.LO !== 32'd0) begin n_err++; $display("FAIL reset_lo: got %h want %h", bus.LO, 32'd0); end
    n_vec++; if (bus.Busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", bus.Busy); end
  endtask

  task automatic test_mult();
    int e; logic h;
    exec(3'd0, 32'hFFFF_FFFF, 32'd2, e, h);
    n_vec++; if (e !== 5) begin n_err++; $display("FAIL mult_latency: got %0d want 5", e); end
    n_vec++; if (h !== 1'b1) begin n_err++; $display("FAIL mult_hold: got %b want 1", h); end
    n_vec++; if (bus.HI !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL mult_hi: got %h want ffffffff", bus.HI); end
    n_vec++; if (bus.LO !== 32'hFFFF_FFFE) begin n_err++; $display("FAIL mult_lo: got %h want fffffffe", bus.LO); end
    exec(3'd1, 32'hFFFF_FFFF, 32'd2, e, h);
    n_vec++; if (e !== 5) begin n_err++; $display("FAIL multu_latency: got %0d want 5", e); end
    n_vec++; if (bus.HI !== 32'h0000_0001) begin n_err++; $display("FAIL multu_hi: got %h want 00000001", bus.HI); end
    n_vec++; if (bus.LO !== 32'hFFFF_FFFE) begin n_err++; $display("FAIL multu_lo: got %h want fffffffe", bus.LO); end
    exec(3'd0, 32'h8000_0000, 32'h8000_0000, e, h);
    n_vec++; if (bus.HI !== 32'h4000_0000) begin n_err++; $display("FAIL mult_min_hi: got %h want 40000000", bus.HI); end
    n_vec++; if (bus.LO !== 32'h0000_0000) begin n_err++; $display("FAIL mult_min_lo: got %h want 00000000", bus.LO); end
  endtask

  task automatic test_div();
    int e; logic h;
    exec(3'd2, 32'hFFFF_FFF9, 32'd2, e, h);
    n_vec++; if (e !== 10) begin n_err++; $display("FAIL div_latency: got %0d want 10", e); end
    n_vec++; if (h !== 1'b1) begin n_err++; $display("FAIL div_hold: got %b want 1", h); end
    n_vec++; if (bus.LO !== 32'hFFFF_FFFD) begin n_err++; $display("FAIL div_lo: got %h want fffffffd", bus.LO); end
    n_vec++; if (bus.HI !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL div_hi: got %h want ffffffff", bus.HI); end
    exec(3'd2, 32'd7, 32'hFFFF_FFFE, e, h);
    n_vec++; if (bus.LO !== 32'hFFFF_FFFD) begin n_err++; $display("FAIL div_negdiv_lo: got %h want fffffffd", bus.LO); end
    n_vec++; if (bus.HI !== 32'd1) begin n_err++; $display("FAIL div_negdiv_hi: got %h want 00000001", bus.HI); end
    exec(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, e, h);
    n_vec++; if (bus.LO !== 32'h8000_0000) begin n_err++; $display("FAIL div_wrap_lo: got %h want 80000000", bus.LO); end
    n_vec++; if (bus.HI !== 32'd0) begin n_err++; $display("FAIL div_wrap_hi: got %h want 00000000", bus.HI); end
    exec(3'd3, 32'd7, 32'd2, e, h);
    n_vec++; if (e !== 10) begin n_err++; $display("FAIL divu_latency: got %0d want 10", e); end
    n_vec++; if (bus.LO !== 32'd3) begin n_err++; $display("FAIL divu_lo: got %h want 00000003", bus.LO); end
    n_vec++; if (bus.HI !== 32'd1) begin n_err++; $display("FAIL divu_hi: got %h want 00000001", bus.HI); end
  endtask

  task automatic test_mthi_mtlo();
    issue(3'd4, 32'h1234_5678, 32'd0);
    n_vec++; if (bus.HI !== 32'h1234_5678) begin n_err++; $display("FAIL mthi_hi: got %h want 12345678", bus.HI); end
    n_vec++; if (bus.LO !== 32'd3) begin n_err++; $display("FAIL mthi_lo: got %h want 00000003", bus.LO); end
    n_vec++; if (bus.Busy !== 1'b0) begin n_err++; $display("FAIL mthi_busy: got %b want 0", bus.Busy); end
    issue(3'd5, 32'h9ABC_DEF0, 32'd0);
    n_vec++; if (bus.LO !== 32'h9ABC_DEF0) begin n_err++; $display("FAIL mtlo_lo: got %h want 9abcdef0", bus.LO); end
    n_vec++; if (bus.HI !== 32'h1234_5678) begin n_err++; $display("FAIL mtlo_hi: got %h want 12345678", bus.HI); end
    n_vec++; if (bus.Busy !== 1'b0) begin n_err++; $display("FAIL mtlo_busy: got %b want 0", bus.Busy); end
    issue(3'd6, 32'hFFFF_0000, 32'd1);
    n_vec++; if (bus.Busy !== 1'b0 || bus.HI !== 32'h1234_5678 || bus.LO !== 32'h9ABC_DEF0) begin
      n_err++; $display("FAIL op6_noeffect: got busy=%b hi=%h lo=%h want 0/12345678/9abcdef0", bus.Busy, bus.HI, bus.LO); end
    issue(3'd7, 32'hFFFF_0000, 32'd1);
    n_vec++; if (bus.Busy !== 1'b0 || bus.HI !== 32'h1234_5678 || bus.LO !== 32'h9ABC_DEF0) begin
      n_err++; $display("FAIL op7_noeffect: got busy=%b hi=%h lo=%h want 0/12345678/9abcdef0", bus.Busy, bus.HI, bus.LO); end
  endtask

  task automatic test_busy_ignore();
    int e; logic h;
    issue(3'd0, 32'd3, 32'd4);
    issue(3'd5, 32'h0000_DEAD, 32'd0);
    n_vec++; if (bus.LO !== 32'h9ABC_DEF0) begin n_err++; $display("FAIL busy_mtlo_lo: got %h want 9abcdef0", bus.LO); end
    n_vec++; if (bus.Busy !== 1'b1) begin n_err++; $display("FAIL busy_mtlo_busy: got %b want 1", bus.Busy); end
    wait_idle(40, e, h);
    n_vec++; if (e !== 4) begin n_err++; $display("FAIL busy_mtlo_remaining: got %0d want 4", e); end
    n_vec++; if (bus.LO !== 32'd12) begin n_err++; $display("FAIL busy_mtlo_commit_lo: got %h want 0000000c", bus.LO); end
    n_vec++; if (bus.HI !== 32'd0) begin n_err++; $display("FAIL busy_mtlo_commit_hi: got %h want 00000000", bus.HI); end
  endtask

  task automatic test_div_zero();
    int e; logic h;
    issue(3'd4, 32'h0000_000A, 32'd0);
    issue(3'd5, 32'h0000_000B, 32'd0);
    exec(3'd2, 32'd5, 32'd0, e, h);
    n_vec++; if (e !== 10) begin n_err++; $display("FAIL div0_latency: got %0d want 10", e); end
    n_vec++; if (bus.HI !== 32'hA || bus.LO !== 32'hB) begin
      n_err++; $display("FAIL div0_hilo: got %h/%h want 0000000a/0000000b", bus.HI, bus.LO); end
    exec(3'd3, 32'hFFFF_FFFF, 32'd0, e, h);
    n_vec++; if (bus.HI !== 32'hA || bus.LO !== 32'hB) begin
      n_err++; $display("FAIL divu0_hilo: got %h/%h want 0000000a/0000000b", bus.HI, bus.LO); end
  endtask

  task automatic test_reset_abort();
    logic quiet;
    issue(3'd4, 32'h55, 32'd0);
    issue(3'd5, 32'h66, 32'd0);
    issue(3'd2, 32'd100, 32'd7);
    step();
    step();
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    n_vec++; if (bus.HI !== 32'd0 || bus.LO !== 32'd0) begin
      n_err++; $display("FAIL abort_hilo: got %h/%h want 00000000/00000000", bus.HI, bus.LO); end
    n_vec++; if (bus.Busy !== 1'b0) begin n_err++; $display("FAIL abort_busy: got %b want 0", bus.Busy); end
    quiet = 1'b1;
    for (int i = 0; i < 15; i++) begin
      step();
      if (bus.Busy !== 1'b0 || bus.HI !== 32'd0 || bus.LO !== 32'd0) quiet = 1'b0;
    end
    n_vec++; if (quiet !== 1'b1) begin n_err++; $display("FAIL abort_no_commit: got %b want 1", quiet); end
  endtask

  task automatic test_reset_priority();
    issue(3'd4, 32'h77, 32'd0);
    bus.Op = 3'd0; bus.RS_IN = 32'd9; bus.RT_IN = 32'd9; bus.Start = 1'b1; Reset = 1'b1;
    step();
    bus.Start = 1'b0; Reset = 1'b0;
    n_vec++; if (bus.Busy !== 1'b0 || bus.HI !== 32'd0) begin
      n_err++; $display("FAIL reset_over_start: got busy=%b hi=%h want 0/00000000", bus.Busy, bus.HI); end
  endtask

  task automatic test_commit_edge();
    issue(3'd0, 32'd2, 32'd3);
    for (int i = 0; i < 4; i++) step();
    n_vec++; if (bus.Busy !== 1'b1) begin n_err++; $display("FAIL commit_edge_prebusy: got %b want 1", bus.Busy); end
    issue(3'd5, 32'h77, 32'd0);
    n_vec++; if (bus.Busy !== 1'b0) begin n_err++; $display("FAIL commit_edge_busy: got %b want 0", bus.Busy); end
    n_vec++; if (bus.LO !== 32'd6 || bus.HI !== 32'd0) begin
      n_err++; $display("FAIL commit_edge_hilo: got %h/%h want 00000000/00000006", bus.HI, bus.LO); end
    issue(3'd5, 32'h77, 32'd0);
    n_vec++; if (bus.LO !== 32'h77) begin n_err++; $display("FAIL after_commit_mtlo: got %h want 00000077", bus.LO); end
    issue(3'd0, 32'd2, 32'd3);
    for (int i = 0; i < 4; i++) step();
    issue(3'd0, 32'd5, 32'd5);
    n_vec++; if (bus.Busy !== 1'b0 || bus.LO !== 32'd6) begin
      n_err++; $display("FAIL commit_edge_mult: got busy=%b lo=%h want 0/00000006", bus.Busy, bus.LO); end
  endtask

  initial begin
    Reset     = 1'b1;
    bus.Start = 1'b0;
    bus.Op    = 3'd0;
    bus.RS_IN = 32'd0;
    bus.RT_IN = 32'd0;
    test_reset();
    test_mult();
    test_div();
    test_mthi_mtlo();
    test_busy_ignore();
    test_div_zero();
    test_reset_abort();
    test_reset_priority();
    test_commit_edge();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
